// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32 main control FSM with retired-instruction counter
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memWrite,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic             adrSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       resultSrc,
    output logic [2:0]       immSrc,
    output logic [2:0]       aluControl,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    state_t           state_q, state_d, decode_d;
    logic [CNT_W-1:0] retired_cnt_q;

    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic       adr_src_c, illegal_c, retire_c;
    logic [1:0] src_a_c, src_b_c, result_src_c;
    logic [2:0] imm_src_c, alu_ctrl_c, alu_fn;
    logic       alu_funct3_bad;

    // Immediate format follows the opcode in every state so the extender is always ready.
    always_comb begin
        imm_src_c = 3'b000;
        case (op)
            OP_STORE: imm_src_c = 3'b001;
            OP_BR:    imm_src_c = 3'b010;
            OP_JAL:   imm_src_c = 3'b011;
            OP_LUI:   imm_src_c = 3'b100;
            default:  imm_src_c = 3'b000;
        endcase
    end

    // ALU operation for the execute states; sub only for R-type with funct7b5.
    always_comb begin
        alu_fn = 3'b000;
        case (funct3)
            3'b000:  alu_fn = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_fn = 3'b101;
            3'b100:  alu_fn = 3'b100;
            3'b110:  alu_fn = 3'b011;
            3'b111:  alu_fn = 3'b010;
            default: alu_fn = 3'b000;
        endcase
    end

    // Legality check and dispatch target chosen while in DECODE.
    always_comb begin
        alu_funct3_bad = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);
        decode_d = S_ILLEGAL;
        case (op)
            OP_LOAD, OP_STORE: decode_d = (funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
            OP_R:    decode_d = (alu_funct3_bad || (funct7b5 && funct3 != 3'b000))
                                ? S_ILLEGAL : S_EXECUTER;
            OP_I:    decode_d = alu_funct3_bad ? S_ILLEGAL : S_EXECUTEI;
            OP_BR:   decode_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_ILLEGAL;
            OP_JAL:  decode_d = S_JAL;
            OP_LUI:  decode_d = S_LUI;
            default: decode_d = S_ILLEGAL;
        endcase
    end

    // Per-state control outputs and next state; anything not set here stays 0.
    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        illegal_c    = 1'b0;
        retire_c     = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        result_src_c = 2'b00;
        alu_ctrl_c   = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                state_d = decode_d;
            end
            S_MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTER: begin
                src_a_c    = 2'b10;
                alu_ctrl_c = alu_fn;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b01;
                alu_ctrl_c = alu_fn;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c    = 2'b10;
                alu_ctrl_c = 3'b001;
                pc_write_c = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                result_src_c = 2'b11;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
            end
            default: state_d = S_ILLEGAL;
        endcase
    end

    // State register and retired-instruction counter; counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            retired_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
        end
    end

    // Reset gates every control output low so an interrupted access stops immediately.
    assign mem_req     = rst_n & mem_req_c;
    assign memWrite    = rst_n & mem_write_c;
    assign irWrite     = rst_n & ir_write_c;
    assign pcWrite     = rst_n & pc_write_c;
    assign regWrite    = rst_n & reg_write_c;
    assign adrSrc      = rst_n & adr_src_c;
    assign illegal     = rst_n & illegal_c;
    assign retire      = rst_n & retire_c;
    assign aluSrcA     = rst_n ? src_a_c      : 2'b00;
    assign aluSrcB     = rst_n ? src_b_c      : 2'b00;
    assign resultSrc   = rst_n ? result_src_c : 2'b00;
    assign immSrc      = rst_n ? imm_src_c    : 3'b000;
    assign aluControl  = rst_n ? alu_ctrl_c   : 3'b000;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main control unit for the multi-cycle RV32 core. It sequences fetch/decode/execute/memory/writeback and drives every datapath select and enable, including the 3-bit immSrc consumed by the immediate extender. It handshakes with the unified instruction/data memory and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps at 2^CNT_W).

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
op  in  7  instr[6:0] from the instruction register.
funct3  in  3  instr[14:12].
funct7b5  in  1  instr[30].
zero  in  1  ALU zero flag (current cycle).
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory access request.
memWrite  out  1  store strobe (valid only with mem_req).
irWrite  out  1  load instruction register and OldPC.
pcWrite  out  1  load PC from Result.
regWrite  out  1  register file write.
adrSrc  out  1  0=PC, 1=Result.
aluSrcA  out  2  00=PC, 01=OldPC, 10=rs1 register.
aluSrcB  out  2  00=rs2 register, 01=imm32, 10=constant 4.
resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=imm32.
immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
illegal  out  1  high in ILLEGAL state.
retire  out  1  one-cycle pulse per completed instruction.
retired_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Single state register; async reset to FETCH, retired_cnt=0. While rst_n=0 all outputs forced 0 (mem_req/enables low, selects 000).
- Outputs combinational from state (plus zero/funct3/mem_ready where noted); unlisted outputs 0 in each state.
- immSrc decoded from op in every state: 0000011/0010011/0110011->000, 0100011->001, 1100011->010, 1101111->011, 0110111->100, else 000.
- FETCH: mem_req=1, adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10. Hold until mem_ready; on the mem_ready cycle irWrite=1, pcWrite=1, ->DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, add (ALUOut=branch/jump target). Next: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BRANCH; 1101111->JAL; 0110111->LUI; else ILLEGAL. Also ILLEGAL if load/store funct3!=010, branch funct3 not 000/001, ALU funct3 in {001,011,101}, or R-type funct7b5=1 with funct3!=000.
- MEMADR: aluSrcA=10, aluSrcB=01, add; ->MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adrSrc=1, resultSrc=00; wait mem_ready, then ->MEMWB.
- MEMWRITE: mem_req=1, memWrite=1, adrSrc=1, resultSrc=00; wait mem_ready, then retire, ->FETCH.
- MEMWB: resultSrc=01, regWrite=1, retire, ->FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00; EXECUTEI: aluSrcA=10, aluSrcB=01; both ->ALUWB.
- ALU decode (funct3): 000 add (sub if R-type and funct7b5), 010 slt, 100 xor, 110 or, 111 and.
- ALUWB: resultSrc=00, regWrite=1, retire, ->FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00; pcWrite=(funct3==000 & zero)|(funct3==001 & ~zero); retire, ->FETCH.
- JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1; ->ALUWB (rd<=OldPC+4).
- LUI: resultSrc=11, regWrite=1, retire, ->FETCH.
- ILLEGAL: illegal=1, all enables 0, mem_req=0; absorbing until reset; no retire.
- retire asserted combinationally in the final cycle; retired_cnt increments on that edge, wraps to 0.
- Reset mid-transaction: mem_req/memWrite/regWrite drop immediately (async); no partial retire counted.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> FETCH,DECODE,EXECUTEI,ALUWB (4 cycles); immSrc=000; regWrite only in ALUWB; retired_cnt 0->1.
- mem_ready low 3 cycles in FETCH -> mem_req held 4 cycles, irWrite/pcWrite high only in 4th; state stays FETCH meanwhile.
- beq (0x00208463) zero=1 -> pcWrite=1 in BRANCH with aluControl=001; repeat zero=0 -> pcWrite=0; bne (funct3=001) zero=0 -> pcWrite=1.
- sw (0x0020a223) mem_ready delayed 2 cycles -> MEMADR then MEMWRITE with memWrite=1, adrSrc=1 for 3 cycles, immSrc=001; retire once.
- lui (0x123450b7) -> immSrc=100, resultSrc=11, regWrite=1 in LUI; jal (0x008000ef) -> JAL pcWrite=1 then ALUWB regWrite=1, immSrc=011.
- op=0000000 -> ILLEGAL, illegal=1 indefinitely, mem_req=0; rst_n pulsed low mid-MEMWRITE -> memWrite drops same cycle, FETCH after release, retired_cnt=0.
